// File: rtl/pc_sequencer.sv
// Instruction sequencer: steps fetch/decode/execute/PC-update, with halt handling,
// a fetch timeout that latches a sticky fault, and a retired-instruction counter.
module pc_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        halt_req,
    input  logic        mem_ack,
    input  logic        exec_done,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        ir_load,
    output logic        exec_start,
    output logic        pc_enable,
    output logic        pc_select,
    output logic        halted,
    output logic        fault,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        UPDATE_PC,
        HALT,
        FAULT
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic       branch_q;
    logic       halt_pending;
    logic       timeout;

    assign timeout = (wait_cnt == 8'(MEM_TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt     <= 8'd0;
            branch_q     <= 1'b0;
            halt_pending <= 1'b0;
            instr_count  <= 16'd0;
        end else begin
            // Every state that can precede FETCH clears the counter, so it is 0 on entry.
            if (state != FETCH) begin
                wait_cnt <= 8'd0;
            end else if (!mem_ack) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if (state == EXECUTE && exec_done) begin
                branch_q <= branch_taken;
            end

            if (state_next == HALT && state != HALT) begin
                halt_pending <= 1'b0;
            end else if (halt_req && state != HALT && state != FAULT) begin
                halt_pending <= 1'b1;
            end

            if (state == UPDATE_PC) begin
                instr_count <= instr_count + 16'd1;
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        state_next = state;
        mem_req    = 1'b0;
        ir_load    = 1'b0;
        exec_start = 1'b0;
        pc_enable  = 1'b0;
        pc_select  = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;

        case (state)
            IDLE: begin
                if (run) state_next = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                // An ack arriving in the timeout cycle still wins.
                if (mem_ack) begin
                    ir_load    = 1'b1;
                    state_next = DECODE;
                end else if (timeout) begin
                    state_next = FAULT;
                end
            end
            DECODE: begin
                exec_start = 1'b1;
                state_next = EXECUTE;
            end
            EXECUTE: begin
                if (exec_done) state_next = UPDATE_PC;
            end
            UPDATE_PC: begin
                pc_enable = 1'b1;
                pc_select = branch_q;
                if (halt_pending)  state_next = HALT;
                else if (!run)     state_next = IDLE;
                else               state_next = FETCH;
            end
            HALT: begin
                halted = 1'b1;
                if (!run && !halt_req) state_next = IDLE;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (MEM_TIMEOUT=3): normal loop, branch, halt,
// run drop mid-instruction, fetch timeout, counter wrap and asynchronous reset.
module tb_pc_sequencer;

    localparam int unsigned TIMEOUT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        halt_req;
    logic        mem_ack;
    logic        exec_done;
    logic        branch_taken;
    logic        mem_req;
    logic        ir_load;
    logic        exec_start;
    logic        pc_enable;
    logic        pc_select;
    logic        halted;
    logic        fault;
    logic [15:0] instr_count;

    int vectors     = 0;
    int miscompares = 0;

    pc_sequencer #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .halt_req     (halt_req),
        .mem_ack      (mem_ack),
        .exec_done    (exec_done),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .ir_load      (ir_load),
        .exec_start   (exec_start),
        .pc_enable    (pc_enable),
        .pc_select    (pc_select),
        .halted       (halted),
        .fault        (fault),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"},     16'(mem_req),     16'd0);
        check({tag, "_ir_load"},     16'(ir_load),     16'd0);
        check({tag, "_exec_start"},  16'(exec_start),  16'd0);
        check({tag, "_pc_enable"},   16'(pc_enable),   16'd0);
        check({tag, "_pc_select"},   16'(pc_select),   16'd0);
        check({tag, "_halted"},      16'(halted),      16'd0);
        check({tag, "_fault"},       16'(fault),       16'd0);
        check({tag, "_instr_count"}, instr_count,      16'd0);
    endtask

    // Entered with the sequencer in its first FETCH cycle.
    task automatic run_instr(input int ack_wait, input int exec_wait, input logic br,
                             input logic hp, input logic [15:0] exp_cnt);
        for (int i = 0; i < ack_wait; i++) begin
            check("fetch_mem_req", 16'(mem_req), 16'd1);
            check("fetch_no_ir_load", 16'(ir_load), 16'd0);
            tick();
        end
        mem_ack = 1'b1;
        #1;
        check("fetch_ack_mem_req", 16'(mem_req), 16'd1);
        check("fetch_ir_load", 16'(ir_load), 16'd1);
        tick();
        mem_ack = 1'b0;
        check("decode_exec_start", 16'(exec_start), 16'd1);
        check("decode_mem_req", 16'(mem_req), 16'd0);
        tick();
        halt_req = hp;
        for (int i = 0; i < exec_wait; i++) begin
            check("exec_no_start", 16'(exec_start), 16'd0);
            check("exec_no_pc_en", 16'(pc_enable), 16'd0);
            tick();
            halt_req = 1'b0;
        end
        exec_done    = 1'b1;
        branch_taken = br;
        tick();
        exec_done    = 1'b0;
        branch_taken = 1'b0;
        halt_req     = 1'b0;
        check("upd_pc_enable", 16'(pc_enable), 16'd1);
        check("upd_pc_select", 16'(pc_select), 16'(br));
        check("upd_cnt_before", instr_count, exp_cnt - 16'd1);
        tick();
        check("post_pc_enable", 16'(pc_enable), 16'd0);
        check("post_pc_select", 16'(pc_select), 16'd0);
        check("post_cnt", instr_count, exp_cnt);
    endtask

    // Structural invariants: strobes mutually exclusive, pc_select only with pc_enable.
    always @(negedge clk) begin
        check("strobe_excl",
              16'((ir_load & exec_start) | (ir_load & pc_enable) | (exec_start & pc_enable)),
              16'd0);
        check("sel_outside_upd", 16'(pc_select & ~pc_enable), 16'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b0;
        run          = 1'b0;
        halt_req     = 1'b0;
        mem_ack      = 1'b0;
        exec_done    = 1'b0;
        branch_taken = 1'b0;

        repeat (2) tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();
        check("idle_no_req", 16'(mem_req), 16'd0);

        // Normal loop: ack two cycles after mem_req, done three cycles after exec_start.
        run = 1'b1;
        tick();
        run_instr(2, 2, 1'b0, 1'b0, 16'd1);
        run_instr(2, 2, 1'b0, 1'b0, 16'd2);
        run_instr(2, 2, 1'b0, 1'b0, 16'd3);

        // Taken branch, then a sequential instruction.
        run_instr(0, 0, 1'b1, 1'b0, 16'd4);
        run_instr(1, 0, 1'b0, 1'b0, 16'd5);

        // halt_req pulsed in EXECUTE: instruction retires, then HALT.
        run_instr(0, 1, 1'b0, 1'b1, 16'd6);
        check("halt_halted", 16'(halted), 16'd1);
        check("halt_no_req", 16'(mem_req), 16'd0);
        tick();
        check("halt_stays_run1", 16'(halted), 16'd1);
        run = 1'b0;
        tick();
        check("halt_exit_idle", 16'(halted), 16'd0);
        check("halt_exit_no_req", 16'(mem_req), 16'd0);

        // run dropped during fetch: instruction completes, then IDLE (no stale halt).
        run = 1'b1;
        tick();
        run = 1'b0;
        run_instr(1, 1, 1'b0, 1'b0, 16'd7);
        check("run0_idle_req", 16'(mem_req), 16'd0);
        check("run0_not_halted", 16'(halted), 16'd0);
        tick();
        check("run0_stays_idle", 16'(mem_req), 16'd0);

        // Fetch timeout: mem_req for TIMEOUT+1 cycles, then sticky fault.
        run = 1'b1;
        tick();
        for (int i = 0; i <= int'(TIMEOUT); i++) begin
            check("to_mem_req", 16'(mem_req), 16'd1);
            check("to_no_fault", 16'(fault), 16'd0);
            tick();
        end
        check("to_fault", 16'(fault), 16'd1);
        check("to_req_dropped", 16'(mem_req), 16'd0);
        mem_ack = 1'b1;
        #1;
        check("fault_no_ir_load", 16'(ir_load), 16'd0);
        tick();
        mem_ack = 1'b0;
        check("fault_sticky", 16'(fault), 16'd1);
        check("fault_no_req", 16'(mem_req), 16'd0);

        // Reset clears the fault; ack in the last allowed cycle beats the timeout.
        rst = 1'b0;
        #1;
        check("fault_rst_fault", 16'(fault), 16'd0);
        check("fault_rst_cnt", instr_count, 16'd0);
        tick();
        rst = 1'b1;
        run = 1'b1;
        tick();
        run = 1'b0;
        run_instr(int'(TIMEOUT), 0, 1'b0, 1'b0, 16'd1);
        check("ack_wins_no_fault", 16'(fault), 16'd0);

        // Counter wrap from a preloaded 0xFFFF.
        force dut.instr_count = 16'hFFFF;
        #1;
        release dut.instr_count;
        #1;
        check("preload_cnt", instr_count, 16'hFFFF);
        run = 1'b1;
        tick();
        run_instr(0, 0, 1'b0, 1'b0, 16'h0000);

        // Asynchronous reset in EXECUTE clears outputs without a clock edge.
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        check("pre_rst_exec_start", 16'(exec_start), 16'd0);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick();
        check("rst_held_idle", 16'(mem_req), 16'd0);
        rst = 1'b1;
        run = 1'b1;
        tick();
        check("resume_fetch", 16'(mem_req), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
